audio_stream_cfg_ctrl: RTL and testbench
========================================

Name: audio_stream_cfg_ctrl

Overview:
- Sequences stream-format changes for the I2S transmit path.
- Accepts a host request (sample rate, bit depth), gates host writes into the output FIFO, and waits for the transmitter to drain.
- Holds the transmitter in reset and switches the MCLK family, with a settle period when the family changes.
- Publishes the new configuration, then acks.
- Sits between the USB command decoder and tx_i2s / the clock-mux logic.

Parameters:
- RESET_CYCLES, 16: cycles tx_reset_o is held high (minimum 2).
- SETTLE_CYCLES, 1024: extra hold after an MCLK family change (PLL/mux settle).
- DRAIN_TIMEOUT, 65535: maximum cycles spent waiting for streaming to stop.

Ports:
- clk_i  in  1  single clock. All logic is on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  one-cycle request strobe.
- cfg_sample_rate_i  in  3  requested rate code; sampled only when cfg_req_i=1.
- cfg_bit_depth_i  in  2  requested depth code; sampled only when cfg_req_i=1.
- streaming_i  in  1  rd_output_FIFO_streaming_o from tx_i2s (asynchronous).
- cfg_ack_o  out  1  one-cycle pulse: new config applied.
- cfg_reject_o  out  1  one-cycle pulse: request refused.
- busy_o  out  1  sequence in progress.
- wr_block_o  out  1  host must not write the output FIFO.
- tx_reset_o  out  1  hold tx_i2s in reset.
- sample_rate_o  out  3  active rate code, to tx_i2s.
- bit_depth_o  out  2  active depth code, to tx_i2s.
- clk_family_o  out  1  0 = 22.5792 MHz family, 1 = 24.576 MHz family.
- drain_timeout_o  out  1  sticky flag: last drain was forced.

Behaviour:
- Input synchronisation: streaming_i passes through a 2-FF synchroniser (streaming_s) before any use.
- Rate codes: 0=44.1k, 1=48k, 2=88.2k, 3=96k, 4=176.4k, 5=192k; 6 and 7 are invalid.
- Clock family: codes 0/2/4 → family 0; codes 1/3/5 → family 1.
- Depth codes: BIT_DEPTH_16, BIT_DEPTH_24, BIT_DEPTH_32, BIT_DEPTH_DOP. DOP is valid only with rate code 4; any other combination with DOP is invalid.
- States: INIT, IDLE, DRAIN, HOLD, SETTLE, DONE.
- Reset values:
  - state=INIT, busy_o=1, wr_block_o=1, tx_reset_o=1
  - sample_rate_o=0, bit_depth_o=BIT_DEPTH_16, clk_family_o=0
  - cfg_ack_o=0, cfg_reject_o=0, drain_timeout_o=0
  - counter=RESET_CYCLES-1
- INIT: count down to 0, then go to IDLE. In IDLE, busy_o, wr_block_o and tx_reset_o are all 0. INIT produces no ack.
- IDLE, on cfg_req_i:
  - Invalid request → cfg_reject_o pulses the next cycle; state and outputs are otherwise unchanged.
  - Valid request equal to the active config → cfg_ack_o pulses the next cycle; no sequence runs.
  - Otherwise → latch the request into pending registers, clear drain_timeout_o, and enter DRAIN. busy_o=1 and wr_block_o=1 from the next cycle.
- cfg_req_i in any state other than IDLE → cfg_reject_o pulses the next cycle. The pending request is unaffected.
- DRAIN:
  - Load the counter with DRAIN_TIMEOUT and count down.
  - streaming_s=0 → enter HOLD.
  - Counter reaches 0 with streaming_s still 1 → set drain_timeout_o=1, then enter HOLD.
- HOLD entry: in the same cycle, tx_reset_o←1, sample_rate_o/bit_depth_o←pending values, clk_family_o←family(pending).
- HOLD: hold for RESET_CYCLES. Then:
  - family changed → SETTLE;
  - family unchanged → DONE.
- SETTLE: hold for SETTLE_CYCLES with tx_reset_o still 1, then go to DONE.
- DONE: a single cycle. tx_reset_o←0, busy_o←0, wr_block_o←0, cfg_ack_o=1, then IDLE.
- Output register ordering:
  - sample_rate_o, bit_depth_o and clk_family_o never change while tx_reset_o=0.
  - tx_reset_o rises no later than the cycle those outputs change.
- Latency, same-family change with streaming_s already 0: ack appears 1 (accept) + 1 (DRAIN) + RESET_CYCLES + 1 cycles after the request edge.
- Counter width: clog2 of max(DRAIN_TIMEOUT, SETTLE_CYCLES, RESET_CYCLES)+1. Counters never wrap; they stop at 0.
- reset_i mid-sequence: the pending request is discarded and the block returns to reset values, including INIT. No ack and no reject are issued.

Decomposition:
- Package audio_cfg_pkg (extends definitions.svh usage):
  - rate-code constants SR_44100..SR_192000;
  - BIT_DEPTH_* constants (shared with tx_i2s);
  - the state enum typedef;
  - function cfg_valid(rate, depth);
  - function rate_family(rate).
- Sub-module sync_2ff (width parameter) for streaming_i. It is reusable elsewhere.

Test Plan:
- Power-up: reset_i for 3 cycles, then released → tx_reset_o=1 and busy_o=1 for exactly RESET_CYCLES=16 cycles, then 0. Outputs read rate=0, depth=BIT_DEPTH_16, family=0; no ack pulse.
- Same-family change, idle stream: request rate=2, depth=BIT_DEPTH_24 with streaming_i=0 → wr_block_o high next cycle; tx_reset_o high 16 cycles; rate_o=2 while in reset; family stays 0; cfg_ack_o 19 cycles after the request.
- Family change while streaming: streaming_i=1, request rate=3 → stays in DRAIN. Drop streaming_i after 100 cycles → HOLD 2 cycles after the sync edge; clk_family_o=1; tx_reset_o high 16+1024 cycles; then ack.
- Drain timeout with DRAIN_TIMEOUT=50: streaming_i held at 1 → drain_timeout_o=1 after 50 cycles in DRAIN; sequence completes with ack. Flag clears on the next accepted request.
- Rejects:
  - rate=6 → reject pulse, no state change;
  - DOP with rate=1 → reject;
  - any request during HOLD → reject, and the original sequence still acks.
- Redundant request and mid-sequence reset:
  - request equal to the active config → ack the next cycle with tx_reset_o staying 0;
  - reset_i asserted during SETTLE → INIT values, no ack.

Source files
------------

// File: rtl/audio_cfg_pkg.sv
// Shared stream-format definitions for the I2S transmit path: rate/depth codes,
// configuration sequencer states and request validation helpers.
package audio_cfg_pkg;

   localparam logic [2:0] SR_44100  = 3'd0;
   localparam logic [2:0] SR_48000  = 3'd1;
   localparam logic [2:0] SR_88200  = 3'd2;
   localparam logic [2:0] SR_96000  = 3'd3;
   localparam logic [2:0] SR_176400 = 3'd4;
   localparam logic [2:0] SR_192000 = 3'd5;

   localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
   localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
   localparam logic [1:0] BIT_DEPTH_32  = 2'd2;
   localparam logic [1:0] BIT_DEPTH_DOP = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_DRAIN,
      ST_HOLD,
      ST_SETTLE,
      ST_DONE
   } cfg_state_e;

   // DoP is only carried at 176.4k; codes above 192k do not exist.
   function automatic logic cfg_valid(input logic [2:0] rate, input logic [1:0] depth);
      if (rate > SR_192000) return 1'b0;
      if ((depth == BIT_DEPTH_DOP) && (rate != SR_176400)) return 1'b0;
      return 1'b1;
   endfunction

   // Odd codes are the 48k multiples (24.576 MHz MCLK), even codes the 44.1k multiples.
   function automatic logic rate_family(input logic [2:0] rate);
      return rate[0];
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level signals.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/audio_stream_cfg_ctrl.sv
// Sequences I2S stream-format changes: drain, hold tx in reset, switch MCLK family,
// settle, publish the new configuration and acknowledge the host.
module audio_stream_cfg_ctrl #(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned DRAIN_TIMEOUT = 65535
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       cfg_req_i,
   input  logic [2:0] cfg_sample_rate_i,
   input  logic [1:0] cfg_bit_depth_i,
   input  logic       streaming_i,
   output logic       cfg_ack_o,
   output logic       cfg_reject_o,
   output logic       busy_o,
   output logic       wr_block_o,
   output logic       tx_reset_o,
   output logic [2:0] sample_rate_o,
   output logic [1:0] bit_depth_o,
   output logic       clk_family_o,
   output logic       drain_timeout_o
);

   import audio_cfg_pkg::*;

   localparam int unsigned CNT_W = $clog2(max3(DRAIN_TIMEOUT, SETTLE_CYCLES, RESET_CYCLES) + 1);
   localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic streaming_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync_streaming (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (streaming_i),
      .q_o     (streaming_s)
   );

   cfg_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       rate_pend_q;
   logic [1:0]       depth_pend_q;
   logic             fam_chg_q;

   logic             ack_q;
   logic             reject_q;
   logic             busy_q;
   logic             wr_block_q;
   logic             tx_reset_q;
   logic [2:0]       rate_q;
   logic [1:0]       depth_q;
   logic             family_q;
   logic             drain_to_q;

   logic req_valid;
   logic req_same;

   assign req_valid = cfg_valid(cfg_sample_rate_i, cfg_bit_depth_i);
   assign req_same  = (cfg_sample_rate_i == rate_q) && (cfg_bit_depth_i == depth_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_INIT;
         cnt_q        <= RST_LOAD;
         rate_pend_q  <= SR_44100;
         depth_pend_q <= BIT_DEPTH_16;
         fam_chg_q    <= 1'b0;
         ack_q        <= 1'b0;
         reject_q     <= 1'b0;
         busy_q       <= 1'b1;
         wr_block_q   <= 1'b1;
         tx_reset_q   <= 1'b1;
         rate_q       <= SR_44100;
         depth_q      <= BIT_DEPTH_16;
         family_q     <= 1'b0;
         drain_to_q   <= 1'b0;
      end else begin
         ack_q    <= 1'b0;
         reject_q <= 1'b0;
         if (cfg_req_i && (state_q != ST_IDLE)) reject_q <= 1'b1;

         case (state_q)
            ST_INIT: begin
               if (cnt_q == '0) begin
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
                  wr_block_q <= 1'b0;
                  tx_reset_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            ST_IDLE: begin
               if (cfg_req_i) begin
                  if (!req_valid) begin
                     reject_q <= 1'b1;
                  end else if (req_same) begin
                     ack_q <= 1'b1;
                  end else begin
                     rate_pend_q  <= cfg_sample_rate_i;
                     depth_pend_q <= cfg_bit_depth_i;
                     drain_to_q   <= 1'b0;
                     busy_q       <= 1'b1;
                     wr_block_q   <= 1'b1;
                     cnt_q        <= DRAIN_LOAD;
                     state_q      <= ST_DRAIN;
                  end
               end
            end

            // Timeout fires on the cycle the counter would reach 0, so DRAIN
            // lasts at most DRAIN_TIMEOUT cycles.
            ST_DRAIN: begin
               if (!streaming_s || (cnt_q <= CNT_ONE)) begin
                  if (streaming_s) drain_to_q <= 1'b1;
                  tx_reset_q <= 1'b1;
                  rate_q     <= rate_pend_q;
                  depth_q    <= depth_pend_q;
                  family_q   <= rate_family(rate_pend_q);
                  fam_chg_q  <= (rate_family(rate_pend_q) != family_q);
                  cnt_q      <= RST_LOAD;
                  state_q    <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            ST_HOLD: begin
               if (cnt_q == '0) begin
                  if (fam_chg_q) begin
                     cnt_q   <= SETTLE_LOAD;
                     state_q <= ST_SETTLE;
                  end else begin
                     tx_reset_q <= 1'b0;
                     state_q    <= ST_DONE;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  tx_reset_q <= 1'b0;
                  state_q    <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            // tx_reset drops on entry; busy/wr_block stay up until the ack pulse.
            ST_DONE: begin
               ack_q      <= 1'b1;
               busy_q     <= 1'b0;
               wr_block_q <= 1'b0;
               state_q    <= ST_IDLE;
            end

            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign cfg_ack_o       = ack_q;
   assign cfg_reject_o    = reject_q;
   assign busy_o          = busy_q;
   assign wr_block_o      = wr_block_q;
   assign tx_reset_o      = tx_reset_q;
   assign sample_rate_o   = rate_q;
   assign bit_depth_o     = depth_q;
   assign clk_family_o    = family_q;
   assign drain_timeout_o = drain_to_q;

endmodule

// File: tb/tb_audio_stream_cfg_ctrl.sv
// Directed bench for audio_stream_cfg_ctrl: default instance plus a short-drain-timeout instance.
module tb_audio_stream_cfg_ctrl;

   import audio_cfg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       req, stream;
   logic [2:0] rate;
   logic [1:0] depth;
   logic       ack, rej, busy, wrb, txr, fam, dto;
   logic [2:0] rate_o;
   logic [1:0] depth_o;

   logic       req2, stream2;
   logic [2:0] rate2;
   logic [1:0] depth2;
   logic       ack2, rej2, busy2, wrb2, txr2, fam2, dto2;
   logic [2:0] rate_o2;
   logic [1:0] depth_o2;

   audio_stream_cfg_ctrl #(
      .RESET_CYCLES  (16),
      .SETTLE_CYCLES (1024),
      .DRAIN_TIMEOUT (65535)
   ) dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .cfg_req_i         (req),
      .cfg_sample_rate_i (rate),
      .cfg_bit_depth_i   (depth),
      .streaming_i       (stream),
      .cfg_ack_o         (ack),
      .cfg_reject_o      (rej),
      .busy_o            (busy),
      .wr_block_o        (wrb),
      .tx_reset_o        (txr),
      .sample_rate_o     (rate_o),
      .bit_depth_o       (depth_o),
      .clk_family_o      (fam),
      .drain_timeout_o   (dto)
   );

   audio_stream_cfg_ctrl #(
      .RESET_CYCLES  (16),
      .SETTLE_CYCLES (1024),
      .DRAIN_TIMEOUT (50)
   ) dut_to (
      .clk_i             (clk),
      .reset_i           (reset),
      .cfg_req_i         (req2),
      .cfg_sample_rate_i (rate2),
      .cfg_bit_depth_i   (depth2),
      .streaming_i       (stream2),
      .cfg_ack_o         (ack2),
      .cfg_reject_o      (rej2),
      .busy_o            (busy2),
      .wr_block_o        (wrb2),
      .tx_reset_o        (txr2),
      .sample_rate_o     (rate_o2),
      .bit_depth_o       (depth_o2),
      .clk_family_o      (fam2),
      .drain_timeout_o   (dto2)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      int unsigned txcnt;
      logic        bad;
      logic        seen;

      reset = 1'b1;  req = 1'b0;  rate = '0;  depth = '0;  stream = 1'b0;
      req2  = 1'b0;  rate2 = '0;  depth2 = '0;  stream2 = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_txr",   txr,     1);
      check("rst_busy",  busy,    1);
      check("rst_wrb",   wrb,     1);
      check("rst_rate",  rate_o,  0);
      check("rst_depth", depth_o, BIT_DEPTH_16);
      check("rst_fam",   fam,     0);
      check("rst_ack",   ack,     0);
      check("rst_rej",   rej,     0);
      check("rst_dto",   dto,     0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Power-up INIT: tx_reset held exactly 16 cycles, no ack
      k = 0;  seen = 1'b0;
      while (txr === 1'b1 && k < 40) begin
         k++;
         if (ack === 1'b1 || ack2 === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      check("init_txr_cycles", k, 16);
      check("init_busy", busy, 0);
      check("init_wrb",  wrb,  0);
      check("init_ack_seen", seen | ack, 0);
      check("init_rate",  rate_o,  0);
      check("init_depth", depth_o, BIT_DEPTH_16);
      check("init_fam",   fam,     0);

      // Same-family change with idle stream
      rate = 3'd2;  depth = BIT_DEPTH_24;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("sf_wrb_next", wrb,  1);
      check("sf_busy",     busy, 1);
      k = 1;  txcnt = 0;  bad = 1'b0;
      while (ack !== 1'b1 && k < 100) begin
         if (txr === 1'b1) begin
            txcnt++;
            if (rate_o !== 3'd2) bad = 1'b1;
         end
         @(negedge clk);
         k++;
      end
      check("sf_ack_latency", k,     19);
      check("sf_txr_cycles",  txcnt, 16);
      check("sf_rate_in_rst", bad,   0);
      check("sf_fam",   fam,     0);
      check("sf_rate",  rate_o,  2);
      check("sf_depth", depth_o, BIT_DEPTH_24);
      check("sf_busy_done", busy, 0);
      check("sf_wrb_done",  wrb,  0);
      @(negedge clk);
      check("sf_ack_pulse", ack, 0);

      // Family change while streaming
      stream = 1'b1;
      repeat (3) @(negedge clk);
      rate = 3'd3;  depth = BIT_DEPTH_24;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (100) @(negedge clk);
      check("fc_drain_busy", busy, 1);
      check("fc_drain_txr",  txr,  0);
      check("fc_drain_wrb",  wrb,  1);
      stream = 1'b0;
      @(negedge clk);
      check("fc_sync_1", txr, 0);
      @(negedge clk);
      check("fc_sync_2", txr, 0);
      @(negedge clk);
      check("fc_hold_txr",  txr,    1);
      check("fc_hold_fam",  fam,    1);
      check("fc_hold_rate", rate_o, 3);
      k = 0;
      while (txr === 1'b1 && k < 3000) begin
         k++;
         @(negedge clk);
      end
      check("fc_txr_cycles", k, 1040);
      @(negedge clk);
      check("fc_ack", ack, 1);
      check("fc_dto", dto, 0);
      @(negedge clk);

      // Rejects: invalid rate, DoP at 48k
      rate = 3'd6;  depth = BIT_DEPTH_16;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("rj6_rej",  rej,    1);
      check("rj6_ack",  ack,    0);
      check("rj6_busy", busy,   0);
      check("rj6_rate", rate_o, 3);
      @(negedge clk);
      check("rj6_pulse", rej, 0);
      rate = 3'd1;  depth = BIT_DEPTH_DOP;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("rjdop_rej",   rej,     1);
      check("rjdop_depth", depth_o, BIT_DEPTH_24);
      @(negedge clk);

      // Request during HOLD is refused; original sequence still completes
      rate = 3'd5;  depth = BIT_DEPTH_32;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      check("rjh_in_hold", txr, 1);
      rate = 3'd0;  depth = BIT_DEPTH_16;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("rjh_rej", rej, 1);
      k = 0;
      while (ack !== 1'b1 && k < 100) begin
         k++;
         @(negedge clk);
      end
      check("rjh_ack_seen", ack,     1);
      check("rjh_rate",     rate_o,  5);
      check("rjh_depth",    depth_o, BIT_DEPTH_32);
      check("rjh_fam",      fam,     1);
      @(negedge clk);

      // Redundant request: immediate ack, no reset
      rate = 3'd5;  depth = BIT_DEPTH_32;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("red_ack",  ack,  1);
      check("red_txr",  txr,  0);
      check("red_busy", busy, 0);
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (txr !== 1'b0 || wrb !== 1'b0) bad = 1'b1;
      end
      check("red_quiet", bad, 0);

      // Reset during SETTLE
      rate = 3'd4;  depth = BIT_DEPTH_16;  req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (30) @(negedge clk);
      check("rs_settle_txr",  txr,    1);
      check("rs_settle_rate", rate_o, 4);
      check("rs_settle_fam",  fam,    0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rs_txr",   txr,     1);
      check("rs_busy",  busy,    1);
      check("rs_wrb",   wrb,     1);
      check("rs_rate",  rate_o,  0);
      check("rs_depth", depth_o, BIT_DEPTH_16);
      check("rs_fam",   fam,     0);
      seen = 1'b0;
      repeat (25) begin
         if (ack === 1'b1 || rej === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      check("rs_no_ack", seen, 0);
      check("rs_idle_txr", txr, 0);

      // Drain timeout on the 50-cycle instance, stream held high
      rate2 = 3'd1;  depth2 = BIT_DEPTH_16;  req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      repeat (49) @(negedge clk);
      check("to_dto_early", dto2,  0);
      check("to_txr_early", txr2,  0);
      check("to_busy",      busy2, 1);
      @(negedge clk);
      check("to_dto", dto2, 1);
      check("to_txr", txr2, 1);
      check("to_fam", fam2, 1);
      k = 0;
      while (ack2 !== 1'b1 && k < 2000) begin
         k++;
         @(negedge clk);
      end
      check("to_ack_seen",  ack2,  1);
      check("to_dto_stick", dto2,  1);
      check("to_busy_done", busy2, 0);
      @(negedge clk);
      rate2 = 3'd0;  depth2 = BIT_DEPTH_16;  req2 = 1'b1;
      @(negedge clk);
      req2 = 1'b0;
      check("to_dto_clear", dto2,  0);
      check("to_busy_new",  busy2, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
